// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter: lock states, requester IDs, default sizes.
// No logic; imported by ram_port_arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } lock_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with an optional forced owner; purely combinational, zero latency.
// A grant is only ever given to a requesting side; with no request the grant is zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_win,
  input  logic       force_vld,
  input  logic       force_id,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (force_vld && req[force_id]) begin
      gnt = force_id ? 2'b10 : 2'b01;
    end else if (req == 2'b11) begin
      // Tie goes to whoever did not win last.
      gnt = last_win ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one sync-read RAM between requesters A and B (round-robin, bounded lock); RAM_ARB_STATS_EN adds transfer counters.
// Grant and RAM command are combinational; read data returns one cycle after the transfer edge; ungranted sides hold their request.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int MAX_LOCK = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a_req,
  input  logic             a_we,
  input  logic             a_lock,
  input  logic [DEPTH-1:0] a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic             b_lock,
  input  logic [DEPTH-1:0] b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  output logic             ram_wr_en,
  output logic             ram_rd_en,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]      a_xfer_cnt,
  output logic [15:0]      b_xfer_cnt
`endif
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

  lock_state_t   state, state_nxt, win_state;
  logic [CW-1:0] lock_cnt, cnt_nxt;
  logic          last_win;
  logic          rd_vld, rd_id;
  logic          force_vld, force_id;
  logic [1:0]    gnt_raw, gnt;
  logic          xfer, win_id, win_we, win_lock;

  // The lock holder keeps priority until its burst budget is spent and the other side is waiting.
  always_comb begin
    force_vld = 1'b0;
    force_id  = REQ_A;
    case (state)
      LOCK_A: begin
        force_vld = a_req;
        force_id  = (lock_cnt == CNT_MAX && b_req) ? REQ_B : REQ_A;
      end
      LOCK_B: begin
        force_vld = b_req;
        force_id  = (lock_cnt == CNT_MAX && a_req) ? REQ_A : REQ_B;
      end
      default: ;
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .req       ({b_req, a_req}),
    .last_win  (last_win),
    .force_vld (force_vld),
    .force_id  (force_id),
    .gnt       (gnt_raw)
  );

  // Reset blanks grants immediately, not just at the next edge.
  assign gnt       = gnt_raw & {2{rstn}};
  assign a_gnt     = gnt[0];
  assign b_gnt     = gnt[1];
  assign xfer      = |gnt;
  assign win_id    = gnt[1];
  assign win_we    = win_id ? b_we : a_we;
  assign win_lock  = win_id ? b_lock : a_lock;
  assign win_state = win_id ? LOCK_B : LOCK_A;

  assign ram_wr_en   = xfer & win_we;
  assign ram_rd_en   = xfer & ~win_we;
  assign ram_addr    = !xfer ? '0 : (win_id ? b_addr : a_addr);
  assign ram_data_in = !xfer ? '0 : (win_id ? b_wdata : a_wdata);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = lock_cnt;
    if (xfer) begin
      if (!win_lock) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else if (state == win_state) begin
        cnt_nxt = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
      end else begin
        state_nxt = win_state;
        cnt_nxt   = CW'(1);
      end
    end else if ((state == LOCK_A && !a_req) || (state == LOCK_B && !b_req)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lock_cnt <= '0;
      last_win <= REQ_B;
      rd_vld   <= 1'b0;
      rd_id    <= REQ_A;
    end else begin
      state    <= state_nxt;
      lock_cnt <= cnt_nxt;
      rd_vld   <= xfer & ~win_we;
      if (xfer) begin
        last_win <= win_id;
        rd_id    <= win_id;
      end
    end
  end

  assign a_rvalid = rd_vld & (rd_id == REQ_A);
  assign b_rvalid = rd_vld & (rd_id == REQ_B);
  assign a_rdata  = a_rvalid ? ram_data_out : '0;
  assign b_rdata  = b_rvalid ? ram_data_out : '0;

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_xfer_cnt <= 16'd0;
      b_xfer_cnt <= 16'd0;
    end else begin
      if (gnt[0] && a_xfer_cnt != 16'hFFFF) a_xfer_cnt <= a_xfer_cnt + 16'd1;
      if (gnt[1] && b_xfer_cnt != 16'hFFFF) b_xfer_cnt <= b_xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one 16x8 synchronous-read RAM between two requesters, A and B.
- Arbitrates each cycle using round-robin priority and drives the RAM command pins.
- Returns read data to the requester that issued the read, tagged with rvalid.
- Optional lock lets one requester hold the RAM for a bounded burst.

Parameters:
WIDTH, 8, data width; must match the RAM.
DEPTH, 4, address bits; the RAM holds 2**DEPTH words.
MAX_LOCK, 4, maximum consecutive locked transfers before a contending requester is forced in; must be at least 1.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
a_req  in  1  A requests an access
a_we  in  1  A access is a write (1) or a read (0)
a_lock  in  1  A asks to keep ownership after this transfer
a_addr  in  DEPTH  A address
a_wdata  in  WIDTH  A write data
a_gnt  out  1  A is granted this cycle (combinational)
a_rvalid  out  1  a_rdata holds A's read result
a_rdata  out  WIDTH  A read data
b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for B
ram_wr_en  out  1  RAM write enable
ram_rd_en  out  1  RAM read enable
ram_addr  out  DEPTH  RAM address
ram_data_in  out  WIDTH  RAM write data
ram_data_out  in  WIDTH  RAM registered read data

Behaviour:
- Transfer: occurs on the rising edge where x_req and x_gnt are both 1. The requester holds req, we, addr and wdata stable until granted.
- Grants are one-hot or zero. A grant is never given without the matching req.
- RAM command outputs are combinational muxes of the granted requester's signals:
  - ram_wr_en = gnt & we
  - ram_rd_en = gnt & ~we
  - With no grant, all RAM outputs are 0.
- Round-robin: last_win register.
  - With both requesting and no lock active, grant the requester that is not last_win.
  - last_win updates on every transfer.
  - Reset value is B, so A wins the first tie.
- Lock FSM states: IDLE, LOCK_A, LOCK_B.
  - IDLE -> LOCK_x: on a transfer by x with x_lock=1; lock_cnt is set to 1.
  - In LOCK_x with x_req=1: x has absolute priority. Each locked transfer increments lock_cnt, which saturates at MAX_LOCK.
  - When lock_cnt == MAX_LOCK and the other requester is requesting: the other requester is granted, and the state moves to IDLE (or to LOCK_other if its lock is set).
  - LOCK_x -> IDLE: on an x transfer with x_lock=0, or when x_req=0 in any cycle. In that cycle the other requester may be granted.
- Read return:
  - A read transfer at edge T makes x_rvalid = 1 for exactly the cycle after T.
  - x_rdata = ram_data_out in that cycle, so latency is 1 cycle.
  - A registered rd_owner tag (valid plus A/B) steers the data.
  - Back-to-back reads from either side are supported, giving a return every cycle.
  - When x_rvalid = 0, x_rdata is 0.
- Write transfers produce no response.
- A write and a read to the same address from different requesters in consecutive cycles are ordered by grant order.
- Reset (asynchronous, any time):
  - state = IDLE, last_win = B, lock_cnt = 0, rd_owner invalid.
  - All gnt, rvalid and RAM enables are 0, and rdata is 0.
  - A read in flight at reset is dropped with no rvalid.
  - RAM contents are not touched.

Optional Feature:
Macro RAM_ARB_STATS_EN.
- Defined: adds outputs a_xfer_cnt and b_xfer_cnt (16 bits each).
  - Each counts that requester's transfers and saturates at 0xFFFF.
  - Both clear on reset.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Shared package ram_arb_pkg holds:
  - lock-state typedef/encodings (IDLE, LOCK_A, LOCK_B)
  - requester-ID constants (REQ_A = 0, REQ_B = 1)
  - default WIDTH/DEPTH constants
- One sub-module, rr_arb2: two-way round-robin grant from req[1:0], last_win and a forced-owner input. Purely combinational.
- The FSM, lock counter, read tag and counters stay in the top module.

Test Plan:
- Reset, then A writes 0x5A to addr 3, then A reads addr 3 → a_gnt=1 on both accesses; a_rvalid=1 one cycle after the read with a_rdata=0x5A; b_rvalid stays 0.
- A and B both request continuously with no lock → grants alternate A,B,A,B starting with A.
- B reads addr 7 (holding 0x11), then A reads addr 2 (holding 0x22) on the next cycle → b_rvalid/0x11, then a_rvalid/0x22 on consecutive cycles, each on its own side only.
- A holds lock with B requesting and MAX_LOCK=4 → A gets 4 consecutive grants, then B is granted; the state returns to IDLE.
- Assert rstn low asynchronously mid-read → rvalid and gnt drop immediately; no rvalid after release; A wins the first tie.
- With RAM_ARB_STATS_EN: 5 A transfers and 3 B transfers → a_xfer_cnt=5, b_xfer_cnt=3; without the macro, the design compiles without these ports.
